// File: rtl/adder_result_history.sv
// Purpose : keeps the last DEPTH adder results {cout, sum}, with a running modulo-256 sum and a saturating carry count.
// Latency : a result is stored at the edge that accepts it; a dump starts one edge after dump_start and runs one entry per cycle.
// Backpressure: res_ready drops while dump_start, clear or a dump is active; dump output has no stall input.
//
// Ports:
//   clk, rst             single clock, asynchronous active-high reset
//   clear                synchronous flush of history, counters and FSM
//   res_valid/res_ready  result handshake; res_sum[3:0], res_cout carry the result
//   dump_start           request to stream the stored history, oldest first
//   dump_valid/data/last registered dump stream, dump_last flags the newest entry
//   count, acc, carry_cnt registered entry count, running sum, carry-out count
module adder_result_history #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       res_valid,
  input  logic [3:0]                 res_sum,
  input  logic                       res_cout,
  output logic                       res_ready,
  input  logic                       dump_start,
  output logic                       dump_valid,
  output logic [W-1:0]               dump_data,
  output logic                       dump_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 acc,
  output logic [7:0]                 carry_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] remaining;   // entries still to present after the current one
  logic [AW-1:0] oldest;
  logic          wr_accept;
  logic          dump_go;

  assign res_ready  = (state == IDLE) && !dump_start && !clear;
  assign wr_accept  = res_valid && res_ready;
  assign dump_go    = (state == IDLE) && dump_start && !clear && (count != '0);
  // The state register is a flop, so dump_valid stays a registered output.
  assign dump_valid = (state == DUMP);

  // When the buffer is full the low bits of count are zero, so the oldest
  // entry is the one the write pointer is about to overwrite.
  assign oldest = wr_ptr - count[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (dump_go) state_nxt = DUMP;
        DUMP:    if (remaining == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Entry storage is not reset; count=0 after reset keeps stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= W'({res_cout, res_sum});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      count     <= '0;
      acc       <= '0;
      carry_cnt <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      count     <= '0;
      acc       <= '0;
      carry_cnt <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != CW'(DEPTH)) begin
          count <= count + CW'(1);
        end
        acc <= acc + {3'b000, res_cout, res_sum};
        if (res_cout && (carry_cnt != 8'hFF)) begin
          carry_cnt <= carry_cnt + 8'd1;
        end
      end

      if (dump_go) begin
        dump_data <= mem[oldest];
        dump_last <= (count == CW'(1));
        rd_ptr    <= oldest + AW'(1);
        remaining <= count - CW'(1);
      end else if (state == DUMP) begin
        if (remaining != '0) begin
          dump_data <= mem[rd_ptr];
          dump_last <= (remaining == CW'(1));
          rd_ptr    <= rd_ptr + AW'(1);
          remaining <= remaining - CW'(1);
        end else begin
          dump_last <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_history.sv
// Purpose : directed self-checking bench for adder_result_history (DEPTH=8, W=5).
// Latency : inputs change 1ns after a rising edge; registered outputs are sampled there too.
// Backpressure: res_ready is checked directly after inputs settle.
module tb_adder_result_history;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       res_valid;
  logic [3:0] res_sum;
  logic       res_cout;
  logic       res_ready;
  logic       dump_start;
  logic       dump_valid;
  logic [4:0] dump_data;
  logic       dump_last;
  logic [3:0] count;
  logic [7:0] acc;
  logic [7:0] carry_cnt;

  int errors = 0;
  int checks = 0;

  adder_result_history #(.DEPTH(8), .W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_ready  (res_ready),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .count      (count),
    .acc        (acc),
    .carry_cnt  (carry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic c, input logic [3:0] s);
    res_valid = 1'b1;
    res_cout  = c;
    res_sum   = s;
    step();
    res_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; res_valid = 1'b0; res_sum = 4'h0;
    res_cout = 1'b0; dump_start = 1'b0;
    #2;
    check("rst_count", count, 0);
    check("rst_acc", acc, 0);
    check("rst_carry", carry_cnt, 0);
    check("rst_dvalid", dump_valid, 0);
    check("rst_ddata", dump_data, 0);
    check("rst_dlast", dump_last, 0);
    step();
    rst = 1'b0;
    step();
    check("idle_ready", res_ready, 1);

    // three entries 03, 05, 1F then a dump
    wr(1'b0, 4'h3);
    wr(1'b0, 4'h5);
    wr(1'b1, 4'hF);
    check("t35_count", count, 3);
    check("t35_acc", acc, 8'h27);
    check("t35_carry", carry_cnt, 1);
    dump_start = 1'b1;
    #1;
    check("t35_ready_on_start", res_ready, 0);
    step();
    dump_start = 1'b0;
    check("t35_v0", dump_valid, 1);
    check("t35_d0", dump_data, 5'h03);
    check("t35_l0", dump_last, 0);
    step();
    check("t35_v1", dump_valid, 1);
    check("t35_d1", dump_data, 5'h05);
    check("t35_l1", dump_last, 0);
    step();
    check("t35_v2", dump_valid, 1);
    check("t35_d2", dump_data, 5'h1F);
    check("t35_l2", dump_last, 1);
    step();
    check("t35_end_valid", dump_valid, 0);
    check("t35_end_last", dump_last, 0);
    check("t35_end_count", count, 3);
    check("t35_end_acc", acc, 8'h27);
    check("t35_end_carry", carry_cnt, 1);

    // overflow: 0..9 into 8 entries
    do_clear();
    check("clr_count", count, 0);
    check("clr_acc", acc, 0);
    check("clr_carry", carry_cnt, 0);
    for (int i = 0; i < 10; i++) wr(1'b0, 4'(i));
    check("t36_count", count, 8);
    check("t36_acc", acc, 8'h2D);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t36_valid", dump_valid, 1);
      check("t36_data", dump_data, 32'(i + 2));
      check("t36_last", dump_last, (i == 7) ? 1 : 0);
      step();
    end
    check("t36_end_valid", dump_valid, 0);

    // dump_start with empty history is ignored
    do_clear();
    dump_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t37_ready", res_ready, 0);
      step();
      check("t37_valid", dump_valid, 0);
    end
    dump_start = 1'b0;
    #1;
    check("t37_ready_back", res_ready, 1);
    step();

    // held result across a 3-entry dump
    do_clear();
    wr(1'b0, 4'h1);
    wr(1'b0, 4'h2);
    wr(1'b0, 4'h3);
    res_valid = 1'b1; res_cout = 1'b0; res_sum = 4'hA;
    dump_start = 1'b1;
    #1;
    check("t38_ready_start", res_ready, 0);
    step();
    dump_start = 1'b0;
    check("t38_ready_d0", res_ready, 0);
    check("t38_data_d0", dump_data, 5'h01);
    step();
    check("t38_ready_d1", res_ready, 0);
    step();
    check("t38_ready_d2", res_ready, 0);
    check("t38_last_d2", dump_last, 1);
    step();
    check("t38_ready_idle", res_ready, 1);
    check("t38_count_pre", count, 3);
    step();
    res_valid = 1'b0;
    check("t38_count_post", count, 4);
    check("t38_acc_post", acc, 8'h10);
    step();
    check("t38_count_once", count, 4);

    // saturation of carry_cnt, acc wrap
    do_clear();
    res_valid = 1'b1; res_cout = 1'b1; res_sum = 4'hF;
    repeat (300) @(posedge clk);
    #1;
    res_valid = 1'b0;
    check("t39_carry", carry_cnt, 8'hFF);
    check("t39_acc", acc, 8'h54);
    check("t39_count", count, 8);

    // clear on the second dump cycle
    do_clear();
    for (int i = 0; i < 4; i++) wr(1'b1, 4'(i + 4));
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("t40_d0", dump_data, 5'h14);
    step();
    check("t40_d1", dump_data, 5'h15);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t40_clr_valid", dump_valid, 0);
    check("t40_clr_last", dump_last, 0);
    check("t40_clr_count", count, 0);
    check("t40_clr_acc", acc, 0);
    check("t40_clr_carry", carry_cnt, 0);

    // asynchronous reset in the middle of a dump
    for (int i = 0; i < 4; i++) wr(1'b1, 4'(i + 1));
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    check("t40_mid_valid", dump_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t40_rst_valid", dump_valid, 0);
    check("t40_rst_data", dump_data, 0);
    check("t40_rst_last", dump_last, 0);
    check("t40_rst_count", count, 0);
    check("t40_rst_acc", acc, 0);
    check("t40_rst_carry", carry_cnt, 0);
    step();
    rst = 1'b0;
    #1;
    wr(1'b0, 4'h7);
    check("t40_after_count", count, 1);
    check("t40_after_acc", acc, 8'h07);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("t40_after_data", dump_data, 5'h07);
    check("t40_after_last", dump_last, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_result_history.md
ADDER_RESULT_HISTORY -- requirements
Module: adder_result_history

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of history entries (power of two, 2..16).
REQ-002 The block SHALL have parameter W, default 5, giving the entry width: {cout, sum[3:0]} from the 4-bit adder stage.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush of history, counters and FSM.
REQ-006 res_valid  input  1  upstream adder result is valid this cycle.
REQ-007 res_sum  input  4  adder sum.
REQ-008 res_cout  input  1  adder carry-out.
REQ-009 res_ready  output  1  block accepts a result this cycle.
REQ-010 dump_start  input  1  request to stream stored history out.
REQ-011 dump_valid  output  1  dump_data/dump_last are valid.
REQ-012 dump_data  output  W  one history entry {cout, sum}.
REQ-013 dump_last  output  1  marks the final entry of a dump.
REQ-014 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-015 acc  output  8  running sum of accepted 5-bit results, modulo 256.
REQ-016 carry_cnt  output  8  number of accepted results with cout=1, saturating.

Function
REQ-017 The block SHALL implement FSM states IDLE and DUMP; state is DUMP exactly when dump_valid is high.
REQ-018 res_ready SHALL equal (state==IDLE) && !dump_start && !clear.
REQ-019 An accepted write (res_valid && res_ready) SHALL store {res_cout, res_sum} at the write pointer and advance the pointer modulo DEPTH.
REQ-020 On an accepted write with count<DEPTH, count SHALL increment; with count==DEPTH, the oldest entry SHALL be overwritten and count SHALL stay DEPTH.
REQ-021 On an accepted write, acc SHALL become (acc + {3'b0, res_cout, res_sum}) mod 256.
REQ-022 On an accepted write with res_cout=1, carry_cnt SHALL increment, holding at 255.
REQ-023 In IDLE, dump_start with count>0 SHALL move the FSM to DUMP at the next edge and present the oldest entry with dump_valid=1.
REQ-024 In DUMP, each subsequent cycle SHALL present the next-older-to-newer entry, one per cycle, with no stalls, for exactly count entries.
REQ-025 dump_last SHALL be high only with the count-th entry; the FSM SHALL return to IDLE at the following edge with dump_valid=0.
REQ-026 A dump SHALL NOT modify stored entries, count, acc or carry_cnt.
REQ-027 dump_start with count==0 SHALL be ignored; the FSM stays IDLE and dump_valid stays 0.
REQ-028 dump_start while in DUMP SHALL be ignored.
REQ-029 res_valid while res_ready=0 SHALL be dropped without side effects; upstream holds data until accepted.
REQ-030 clear SHALL take priority over writes and dump_start: next edge count=0, pointers=0, acc=0, carry_cnt=0, FSM=IDLE, dump_valid=0, dump_last=0.
REQ-031 All outputs except res_ready SHALL be registered.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE, count=0, pointers=0, acc=0, carry_cnt=0, dump_valid=0, dump_data=0, dump_last=0, independent of clk.
REQ-033 Reset mid-dump SHALL abort the dump; entry storage contents need not be cleared, but they SHALL be unreachable because count=0.
REQ-034 Deasserting rst SHALL allow normal operation from the first following rising edge.

Verification
REQ-035 Write 3,5,F with cout=0,0,1 (entries 03,05,1F), then dump_start -> dump_data 03,05,1F on three consecutive cycles, dump_last on 1F only, count=3, acc=0x27, carry_cnt=1.
REQ-036 Write values 0..9 (cout=0) into DEPTH=8 -> count=8; dump yields 02..09, acc=0x2D.
REQ-037 dump_start with count=0 -> dump_valid stays 0 for 4 cycles; res_ready returns high the cycle dump_start drops.
REQ-038 res_valid held high through dump_start and a 3-entry dump -> res_ready low for dump_start cycle plus 3 dump cycles; the held value is accepted exactly once afterwards.
REQ-039 Write 300 results of 1F -> carry_cnt=255, acc=(300*31) mod 256=0x54.
REQ-040 clear asserted on second dump cycle of a 4-entry dump -> next edge dump_valid=0, count=0, acc=0; rst asserted mid-dump asynchronously zeroes all outputs before the next clk edge.
